control_register_scheduler: RTL and testbench
=============================================

Name: control_register_scheduler

Overview:
- Sequences all writes into the 8x8 control register file and shares its ports between two requesters.
- Requesters: the host bus interface (MCU side) and the internal frame sequencer.
- Host writes are buffered and committed only while vblank is high, so mid-frame register changes never tear the picture. Internal writes commit immediately.
- Also provides a one-outstanding host read path onto the register file read port.

Parameters:
- ADDR_W, 3, register address width (8 registers)
- DATA_W, 8, register data width
- FIFO_DEPTH, 4, host write buffer entries (power of two, >=2)

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- host_wr_valid  in  1  host write request
- host_wr_ready  out  1  buffer can accept; transfer when valid&&ready
- host_wr_addr  in  ADDR_W  host write address
- host_wr_data  in  DATA_W  host write data
- int_wr_valid  in  1  internal write strobe, single-cycle, always accepted
- int_wr_addr  in  ADDR_W  internal write address
- int_wr_data  in  DATA_W  internal write data
- vblank  in  1  level; high = commit window open
- host_rd_req  in  1  read request pulse
- host_rd_addr  in  ADDR_W  read address
- host_rd_busy  out  1  read in flight
- host_rd_valid  out  1  one-cycle pulse, host_rd_data valid
- host_rd_data  out  DATA_W  read result
- fifo_level  out  $clog2(FIFO_DEPTH)+1  buffered host writes
- write_addr  out  ADDR_W  to register file
- write_data  out  DATA_W  to register file
- write_enable  out  1  to register file
- read_addr  out  ADDR_W  to register file
- read_data  in  DATA_W  from register file

Behaviour:

Reset:
- All outputs are 0, except host_wr_ready, which is 1.
- FIFO is flushed and pointers are zeroed. Read state returns to R_IDLE.
- Reset asserted mid-drain or mid-read aborts the operation; no write_enable is issued after reset asserts.

Host buffer:
- host_wr_ready = (fifo_level < FIFO_DEPTH).
- An accepted transfer is pushed in the same edge.
- When full, ready is 0 even if a pop occurs that cycle; no push happens.
- Entries are committed in FIFO order. Pointers wrap modulo FIFO_DEPTH.

Write arbitration (evaluated each cycle):
- Priority 1: int_wr_valid wins. On the next edge, write_addr/write_data = int_wr_* and write_enable = 1.
- Priority 2: otherwise, if vblank=1 and fifo_level>0, pop the head. On the next edge, write_* = head and write_enable = 1.
- Otherwise write_enable = 0 on the next edge.
- write_* outputs are registered, giving 1-cycle latency. A write lands in the register file on the edge after that (total 2 edges from request).
- Drain rate is one entry per cycle. An internal write stalls the drain for that cycle only.
- If vblank falls, draining stops at that edge. A pop already decided in the last vblank cycle completes. The remaining entries wait for the next vblank.
- A push and a pop in the same cycle leave fifo_level unchanged.
- Same-address collision between the internal write and the FIFO head: the internal write commits first and the FIFO entry later, so the host value overwrites it.

Read FSM:
- R_IDLE: on host_rd_req, read_addr <= host_rd_addr, host_rd_busy <= 1, go to R_WAIT.
- R_WAIT: one cycle, then go to R_CAPTURE.
- R_CAPTURE: host_rd_data <= read_data, host_rd_valid <= 1 for one cycle, host_rd_busy <= 0, go to R_IDLE.
- Read latency: host_rd_valid is asserted 3 edges after the req edge.
- host_rd_req while busy is ignored.
- read_addr holds its last value in R_IDLE.
- Reads return register-file contents only, never pending FIFO entries.
- The read port is independent of write arbitration; a read never stalls writes.

Test Plan:
- vblank=0; host writes (1,0x11),(2,0x22),(3,0x33),(4,0x44) -> fifo_level=4, host_wr_ready=0, write_enable stays 0. A 5th write is held. Raise vblank -> four consecutive write_enable pulses in order, fifo_level reaches 0, and the held 5th write is accepted once level<4.
- vblank=1, FIFO holds (5,0xA5); int_wr (5,0x5A) in the same cycle -> write (5,0x5A) issued first, then (5,0xA5) next cycle. Read addr 5 afterwards returns 0xA5.
- Drain of 3 entries; vblank falls after the first pop -> exactly one write issued, fifo_level=2. Next vblank drains the remaining two in order.
- Read at addr 1 after an internal write of 0x07 -> host_rd_valid pulses 3 edges after req with data 0x07. A second req while host_rd_busy=1 produces no extra valid pulse.
- Simultaneous push and pop at fifo_level=2 during vblank -> level stays 2 and ordering is preserved. Pointers wrap over 10 push/pop pairs without corruption.
- Assert reset_n=0 mid-drain with 3 entries queued -> write_enable=0 immediately, fifo_level=0, host_wr_ready=1. After release, no stale writes are issued.

Source files
------------

// File: rtl/control_register_scheduler_if.sv
// rtl/control_register_scheduler_if.sv - host-side write/read bus of the control register scheduler
interface control_register_scheduler_if #(
   parameter int ADDR_W     = 3,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              host_wr_valid;
   logic              host_wr_ready;
   logic [ADDR_W-1:0] host_wr_addr;
   logic [DATA_W-1:0] host_wr_data;
   logic              host_rd_req;
   logic [ADDR_W-1:0] host_rd_addr;
   logic              host_rd_busy;
   logic              host_rd_valid;
   logic [DATA_W-1:0] host_rd_data;
   logic [LVL_W-1:0]  fifo_level;

   modport master (
      output host_wr_valid, host_wr_addr, host_wr_data, host_rd_req, host_rd_addr,
      input  host_wr_ready, host_rd_busy, host_rd_valid, host_rd_data, fifo_level
   );

   modport slave (
      input  host_wr_valid, host_wr_addr, host_wr_data, host_rd_req, host_rd_addr,
      output host_wr_ready, host_rd_busy, host_rd_valid, host_rd_data, fifo_level
   );
endinterface

// File: rtl/control_register_scheduler.sv
// rtl/control_register_scheduler.sv - arbitrates internal and vblank-gated buffered host writes into
// the control register file and runs a single-outstanding host read path.
module control_register_scheduler #(
   parameter int ADDR_W     = 3,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   control_register_scheduler_if.slave host,
   input  logic                        int_wr_valid,
   input  logic [ADDR_W-1:0]           int_wr_addr,
   input  logic [DATA_W-1:0]           int_wr_data,
   input  logic                        vblank,
   output logic [ADDR_W-1:0]           write_addr,
   output logic [DATA_W-1:0]           write_data,
   output logic                        write_enable,
   output logic [ADDR_W-1:0]           read_addr,
   input  logic [DATA_W-1:0]           read_data
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_CAPTURE} rd_state_e;

   logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              wr_ready;
   logic              push;
   logic              pop;

   logic [ADDR_W-1:0] write_addr_q;
   logic [DATA_W-1:0] write_data_q;
   logic              write_enable_q;

   rd_state_e         rd_state_q;
   logic [ADDR_W-1:0] read_addr_q;
   logic              rd_busy_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;

   // Ready depends only on the registered level, so a same-cycle pop never frees a full buffer.
   assign wr_ready = (level_q < LVL_W'(FIFO_DEPTH));
   assign push     = host.host_wr_valid && wr_ready;
   assign pop      = !int_wr_valid && vblank && (level_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= host.host_wr_addr;
         data_mem[wr_ptr_q] <= host.host_wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_addr_q   <= '0;
         write_data_q   <= '0;
         write_enable_q <= 1'b0;
      end else if (int_wr_valid) begin
         write_addr_q   <= int_wr_addr;
         write_data_q   <= int_wr_data;
         write_enable_q <= 1'b1;
      end else if (pop) begin
         write_addr_q   <= addr_mem[rd_ptr_q];
         write_data_q   <= data_mem[rd_ptr_q];
         write_enable_q <= 1'b1;
      end else begin
         write_enable_q <= 1'b0;
      end
   end

   // The WAIT state gives a registered register-file read port a full cycle to respond.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_state_q  <= R_IDLE;
         read_addr_q <= '0;
         rd_busy_q   <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         rd_valid_q <= 1'b0;
         case (rd_state_q)
            R_IDLE: begin
               if (host.host_rd_req) begin
                  read_addr_q <= host.host_rd_addr;
                  rd_busy_q   <= 1'b1;
                  rd_state_q  <= R_WAIT;
               end
            end
            R_WAIT: begin
               rd_state_q <= R_CAPTURE;
            end
            R_CAPTURE: begin
               rd_data_q  <= read_data;
               rd_valid_q <= 1'b1;
               rd_busy_q  <= 1'b0;
               rd_state_q <= R_IDLE;
            end
            default: begin
               rd_busy_q  <= 1'b0;
               rd_state_q <= R_IDLE;
            end
         endcase
      end
   end

   assign host.host_wr_ready = wr_ready;
   assign host.fifo_level    = level_q;
   assign host.host_rd_busy  = rd_busy_q;
   assign host.host_rd_valid = rd_valid_q;
   assign host.host_rd_data  = rd_data_q;
   assign write_addr         = write_addr_q;
   assign write_data         = write_data_q;
   assign write_enable       = write_enable_q;
   assign read_addr          = read_addr_q;
endmodule

// File: tb/tb_control_register_scheduler.sv
// tb/tb_control_register_scheduler.sv - directed vector bench for control_register_scheduler
module tb_control_register_scheduler;
   logic       clk;
   logic       reset_n;
   logic       int_wr_valid;
   logic [2:0] int_wr_addr;
   logic [7:0] int_wr_data;
   logic       vblank;
   logic [2:0] write_addr;
   logic [7:0] write_data;
   logic       write_enable;
   logic [2:0] read_addr;
   logic [7:0] read_data;
   logic [7:0] rf [8];

   int checks;
   int errors;

   control_register_scheduler_if #(.ADDR_W(3), .DATA_W(8), .FIFO_DEPTH(4)) bus ();

   control_register_scheduler #(.ADDR_W(3), .DATA_W(8), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .host         (bus),
      .int_wr_valid (int_wr_valid),
      .int_wr_addr  (int_wr_addr),
      .int_wr_data  (int_wr_data),
      .vblank       (vblank),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .write_enable (write_enable),
      .read_addr    (read_addr),
      .read_data    (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: a write is stored on the edge after write_enable is presented.
   always @(posedge clk) if (write_enable) rf[write_addr] <= write_data;
   assign read_data = rf[read_addr];

   typedef struct {
      logic       iv;
      logic [2:0] ia;
      logic [7:0] id;
      logic       vb;
      logic       hv;
      logic [2:0] ha;
      logic [7:0] hd;
      logic       ewe;
      logic [2:0] ewa;
      logic [7:0] ewd;
      int         elvl;
      logic       erdy;
   } vec_t;

   vec_t vecs[$];
   logic [10:0] model_q[$];

   task automatic add(input logic iv, input logic [2:0] ia, input logic [7:0] id, input logic vb,
                      input logic hv, input logic [2:0] ha, input logic [7:0] hd,
                      input logic ewe, input logic [2:0] ewa, input logic [7:0] ewd,
                      input int elvl, input logic erdy);
      vec_t v;
      v = '{iv, ia, id, vb, hv, ha, hd, ewe, ewa, ewd, elvl, erdy};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      int_wr_valid      = 1'b0;
      int_wr_addr       = '0;
      int_wr_data       = '0;
      bus.host_wr_valid = 1'b0;
      bus.host_wr_addr  = '0;
      bus.host_wr_data  = '0;
      bus.host_rd_req   = 1'b0;
      bus.host_rd_addr  = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 8; i++) rf[i] = 8'h00;
      reset_n = 1'b0;
      vblank  = 1'b0;
      idle_inputs();

      // fill, hold 5th write, drain in order
      add(0,0,8'h00, 0, 1,1,8'h11, 0,0,8'h00, 1, 1);
      add(0,0,8'h00, 0, 1,2,8'h22, 0,0,8'h00, 2, 1);
      add(0,0,8'h00, 0, 1,3,8'h33, 0,0,8'h00, 3, 1);
      add(0,0,8'h00, 0, 1,4,8'h44, 0,0,8'h00, 4, 0);
      add(0,0,8'h00, 0, 1,5,8'h55, 0,0,8'h00, 4, 0);
      add(0,0,8'h00, 1, 1,5,8'h55, 1,1,8'h11, 3, 1);
      add(0,0,8'h00, 1, 1,5,8'h55, 1,2,8'h22, 3, 1);
      add(0,0,8'h00, 1, 0,0,8'h00, 1,3,8'h33, 2, 1);
      add(0,0,8'h00, 1, 0,0,8'h00, 1,4,8'h44, 1, 1);
      add(0,0,8'h00, 1, 0,0,8'h00, 1,5,8'h55, 0, 1);
      add(0,0,8'h00, 1, 0,0,8'h00, 0,0,8'h00, 0, 1);
      // same-address collision
      add(0,0,8'h00, 0, 1,5,8'hA5, 0,0,8'h00, 1, 1);
      add(1,5,8'h5A, 1, 0,0,8'h00, 1,5,8'h5A, 1, 1);
      add(0,0,8'h00, 1, 0,0,8'h00, 1,5,8'hA5, 0, 1);
      add(0,0,8'h00, 0, 0,0,8'h00, 0,0,8'h00, 0, 1);
      // vblank falls after first pop
      add(0,0,8'h00, 0, 1,1,8'h01, 0,0,8'h00, 1, 1);
      add(0,0,8'h00, 0, 1,2,8'h02, 0,0,8'h00, 2, 1);
      add(0,0,8'h00, 0, 1,3,8'h03, 0,0,8'h00, 3, 1);
      add(0,0,8'h00, 1, 0,0,8'h00, 1,1,8'h01, 2, 1);
      add(0,0,8'h00, 0, 0,0,8'h00, 0,0,8'h00, 2, 1);
      add(0,0,8'h00, 0, 0,0,8'h00, 0,0,8'h00, 2, 1);
      add(0,0,8'h00, 1, 0,0,8'h00, 1,2,8'h02, 1, 1);
      add(0,0,8'h00, 1, 0,0,8'h00, 1,3,8'h03, 0, 1);
      // simultaneous push and pop at level 2
      add(0,0,8'h00, 0, 1,6,8'h61, 0,0,8'h00, 1, 1);
      add(0,0,8'h00, 0, 1,7,8'h71, 0,0,8'h00, 2, 1);
      add(0,0,8'h00, 1, 1,6,8'h62, 1,6,8'h61, 2, 1);
      add(0,0,8'h00, 1, 1,7,8'h72, 1,7,8'h71, 2, 1);
      add(0,0,8'h00, 1, 0,0,8'h00, 1,6,8'h62, 1, 1);
      add(0,0,8'h00, 1, 0,0,8'h00, 1,7,8'h72, 0, 1);

      #3;
      check("reset write_enable", write_enable, 0);
      check("reset write_addr", write_addr, 0);
      check("reset write_data", write_data, 0);
      check("reset read_addr", read_addr, 0);
      check("reset rd_busy", bus.host_rd_busy, 0);
      check("reset rd_valid", bus.host_rd_valid, 0);
      check("reset rd_data", bus.host_rd_data, 0);
      check("reset fifo_level", bus.fifo_level, 0);
      check("reset wr_ready", bus.host_wr_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         int_wr_valid      = vecs[i].iv;
         int_wr_addr       = vecs[i].ia;
         int_wr_data       = vecs[i].id;
         vblank            = vecs[i].vb;
         bus.host_wr_valid = vecs[i].hv;
         bus.host_wr_addr  = vecs[i].ha;
         bus.host_wr_data  = vecs[i].hd;
         tick();
         check($sformatf("v%0d write_enable", i), write_enable, vecs[i].ewe);
         if (vecs[i].ewe) begin
            check($sformatf("v%0d write_addr", i), write_addr, vecs[i].ewa);
            check($sformatf("v%0d write_data", i), write_data, vecs[i].ewd);
         end
         check($sformatf("v%0d fifo_level", i), bus.fifo_level, vecs[i].elvl);
         check($sformatf("v%0d wr_ready", i), bus.host_wr_ready, vecs[i].erdy);
      end
      idle_inputs();

      // pointer wrap: prime two entries, then ten push/pop pairs against a queue model
      vblank = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.host_wr_valid = 1'b1;
         bus.host_wr_addr  = 3'(6 + i);
         bus.host_wr_data  = 8'(8'hC0 + i);
         model_q.push_back({bus.host_wr_addr, bus.host_wr_data});
         tick();
      end
      vblank = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic [10:0] exp_e;
         bus.host_wr_valid = 1'b1;
         bus.host_wr_addr  = 3'(6 + (i % 2));
         bus.host_wr_data  = 8'(8'h80 + i);
         exp_e = model_q.pop_front();
         model_q.push_back({bus.host_wr_addr, bus.host_wr_data});
         tick();
         check($sformatf("wrap%0d write", i), {write_enable, write_addr, write_data}, {1'b1, exp_e});
         check($sformatf("wrap%0d fifo_level", i), bus.fifo_level, 2);
      end
      bus.host_wr_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         logic [10:0] exp_e;
         exp_e = model_q.pop_front();
         tick();
         check($sformatf("wrap drain%0d write", i), {write_enable, write_addr, write_data}, {1'b1, exp_e});
      end
      tick();
      check("wrap empty level", bus.fifo_level, 0);
      vblank = 1'b0;

      // internal write then read back with latency and busy-ignore checks
      int_wr_valid = 1'b1;
      int_wr_addr  = 3'd1;
      int_wr_data  = 8'h07;
      tick();
      check("int write", {write_enable, write_addr, write_data}, {1'b1, 3'd1, 8'h07});
      int_wr_valid = 1'b0;
      tick();
      bus.host_rd_req  = 1'b1;
      bus.host_rd_addr = 3'd1;
      tick();
      check("rd edge1 busy", bus.host_rd_busy, 1);
      check("rd edge1 valid", bus.host_rd_valid, 0);
      check("rd edge1 read_addr", read_addr, 1);
      bus.host_rd_addr = 3'd5;
      tick();
      check("rd edge2 valid", bus.host_rd_valid, 0);
      check("rd edge2 read_addr", read_addr, 1);
      bus.host_rd_req = 1'b0;
      tick();
      check("rd edge3 valid", bus.host_rd_valid, 1);
      check("rd edge3 data", bus.host_rd_data, 8'h07);
      check("rd edge3 busy", bus.host_rd_busy, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rd no extra pulse %0d", i), {bus.host_rd_valid, bus.host_rd_busy}, 2'b00);
      end
      bus.host_rd_req  = 1'b1;
      bus.host_rd_addr = 3'd5;
      tick();
      bus.host_rd_req = 1'b0;
      tick();
      tick();
      check("rd addr5 valid", bus.host_rd_valid, 1);
      check("rd addr5 data", bus.host_rd_data, 8'hA5);
      tick();
      check("read_addr holds", read_addr, 5);

      // reset mid-drain
      for (int i = 0; i < 3; i++) begin
         bus.host_wr_valid = 1'b1;
         bus.host_wr_addr  = 3'(2 + i);
         bus.host_wr_data  = 8'(8'hE0 + i);
         tick();
      end
      bus.host_wr_valid = 1'b0;
      vblank = 1'b1;
      tick();
      check("pre-reset drain write", {write_enable, write_addr, write_data}, {1'b1, 3'd2, 8'hE0});
      #2;
      reset_n = 1'b0;
      #1;
      check("mid-reset write_enable", write_enable, 0);
      check("mid-reset fifo_level", bus.fifo_level, 0);
      check("mid-reset wr_ready", bus.host_wr_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("post-reset no write %0d", i), write_enable, 0);
         check($sformatf("post-reset level %0d", i), bus.fifo_level, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
